// File: rtl/bpu_pkg.sv
// bpu_pkg: shared branch-predictor types (2-bit counters, BTB entry layout)
package bpu_pkg;
    typedef logic [1:0] ctr2_t;
    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;
    localparam int WIDTH   = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_W   = WIDTH - IDX_W - 2;
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] target;
        ctr2_t            ctr;
    } btb_entry_t;
endpackage

// File: rtl/sat_ctr2.sv
// sat_ctr2: next value of a 2-bit saturating direction counter
// ctr: current value; taken: resolved direction; force_strong: jump, jump straight to strong taken
// ctr_nxt: updated counter, never wraps past 00 or 11
module sat_ctr2
    import bpu_pkg::*;
(
    input  ctr2_t ctr,
    input  logic  taken,
    input  logic  force_strong,
    output ctr2_t ctr_nxt
);
    always_comb
        ctr_nxt = force_strong ? CTR_ST :
                  taken        ? ((ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1) :
                                 ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
endmodule

// File: rtl/btb.sv
// btb: direct-mapped branch target buffer with 2-bit direction counters
// clk/rst: clock, sync active-high reset; pc_fetch -> branch_en/pc_target: combinational lookup
// upd_*: execute-stage resolution port, commits at the next edge; clr: invalidate all entries
module btb #(
    parameter int WIDTH   = bpu_pkg::WIDTH,
    parameter int ENTRIES = bpu_pkg::ENTRIES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_fetch,
    output logic             branch_en,
    output logic [WIDTH-1:0] pc_target,
    input  logic             upd_en,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic             upd_is_jump,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             clr
);
    import bpu_pkg::*;
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WIDTH - IDX_W - 2;
    btb_entry_t       mem_q [ENTRIES];
    btb_entry_t       mem_d [ENTRIES];
    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             u_hit;
    ctr2_t            u_ctr_nxt;
    assign f_idx = pc_fetch[IDX_W+1:2];
    assign f_tag = pc_fetch[WIDTH-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[WIDTH-1:IDX_W+2];
    assign u_hit = mem_q[u_idx].valid && mem_q[u_idx].tag == u_tag;
    sat_ctr2 u_sat (
        .ctr          (mem_q[u_idx].ctr),
        .taken        (upd_taken),
        .force_strong (upd_is_jump),
        .ctr_nxt      (u_ctr_nxt)
    );
    // clr takes priority so a same-cycle update can never resurrect an entry
    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < ENTRIES; i++) mem_d[i].valid = 1'b0;
        end else if (upd_en && u_hit) begin
            mem_d[u_idx].ctr = u_ctr_nxt;
            if (upd_taken) mem_d[u_idx].target = upd_target;
        end else if (upd_en && upd_taken) begin
            mem_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: upd_target,
                             ctr: upd_is_jump ? CTR_ST : CTR_WT};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
        end else begin
            mem_q <= mem_d;
        end
    end
    assign branch_en = mem_q[f_idx].valid && mem_q[f_idx].tag == f_tag && mem_q[f_idx].ctr[1];
    assign pc_target = mem_q[f_idx].target;
endmodule

// File: tb/tb_btb.sv
// tb_btb: directed stimulus against a line-addressed reference model of the BTB
module tb_btb;
    logic        clk = 0, rst = 1;
    logic [31:0] pc_fetch = '0, pc_target, upd_pc = '0, upd_target = '0;
    logic        branch_en, upd_en = 0, upd_taken = 0, upd_is_jump = 0, clr = 0;
    logic        run = 0;
    int          checks = 0, errors = 0;

    btb dut (
        .clk(clk), .rst(rst), .pc_fetch(pc_fetch), .branch_en(branch_en), .pc_target(pc_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
        .upd_target(upd_target), .clr(clr)
    );

    always #5 clk = ~clk;

    // Reference model: each slot remembers the full word address (pc>>2) it holds
    logic        m_valid  [16];
    logic [29:0] m_line   [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    int          uk, fk;

    function automatic int ix(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    always_comb uk = ix(upd_pc);
    always_comb fk = ix(pc_fetch);

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i]  <= 1'b0;
                m_line[i]   <= '0;
                m_target[i] <= '0;
                m_ctr[i]    <= 1;
            end
        end else if (clr) begin
            for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
        end else if (upd_en) begin
            if (m_valid[uk] && m_line[uk] == upd_pc[31:2]) begin
                m_ctr[uk] <= upd_is_jump ? 3 :
                             upd_taken   ? ((m_ctr[uk] < 3) ? m_ctr[uk] + 1 : 3) :
                                           ((m_ctr[uk] > 0) ? m_ctr[uk] - 1 : 0);
                if (upd_taken) m_target[uk] <= upd_target;
            end else if (upd_taken) begin
                m_valid[uk]  <= 1'b1;
                m_line[uk]   <= upd_pc[31:2];
                m_target[uk] <= upd_target;
                m_ctr[uk]    <= upd_is_jump ? 3 : 2;
            end
        end
    end

    // Every cycle: lookup outputs against the model, and the counter never wraps
    always @(negedge clk) begin
        if (run && !rst) begin
            chk("model_branch_en", 32'(branch_en),
                32'(m_valid[fk] && m_line[fk] == pc_fetch[31:2] && m_ctr[fk] >= 2));
            chk("model_pc_target", pc_target, m_target[fk]);
            checks++;
            assert (!(dut.u_sat.ctr == 2'b11 && dut.u_sat.taken && dut.u_sat.ctr_nxt != 2'b11) &&
                    !(dut.u_sat.ctr == 2'b00 && !dut.u_sat.taken && !dut.u_sat.force_strong &&
                      dut.u_sat.ctr_nxt != 2'b00))
            else begin
                errors++;
                $display("FAIL ctr_wrap: ctr %b next %b", dut.u_sat.ctr, dut.u_sat.ctr_nxt);
            end
        end
    end

    // Drive one cycle of inputs just after the edge; return at mid-cycle for sampling
    task automatic drive(input logic u, input logic [31:0] upc, input logic tk, input logic jp,
                         input logic [31:0] tgt, input logic c, input logic [31:0] fpc);
        @(posedge clk);
        #1;
        upd_en = u; upd_pc = upc; upd_taken = tk; upd_is_jump = jp;
        upd_target = tgt; clr = c; pc_fetch = fpc;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(0, '0, 0, 0, '0, 0, fpc);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        run = 1;
        idle(32'h100);
        chk("reset_be", 32'(branch_en), 0);
        chk("reset_tgt", pc_target, 32'h0);
        drive(1, 32'h100, 1, 0, 32'h200, 0, 32'h100);
        chk("alloc_same_cycle_be", 32'(branch_en), 0);
        idle(32'h100);
        chk("alloc_be", 32'(branch_en), 1);
        chk("alloc_tgt", pc_target, 32'h200);
        chk("alloc_ctr", 32'(dut.mem_q[0].ctr), 2);
        drive(1, 32'h100, 0, 0, 32'h0, 0, 32'h100);
        chk("nt1_pre_be", 32'(branch_en), 1);
        drive(1, 32'h100, 0, 0, 32'h0, 0, 32'h100);
        chk("nt1_ctr", 32'(dut.mem_q[0].ctr), 1);
        chk("nt1_be", 32'(branch_en), 0);
        idle(32'h100);
        chk("nt2_ctr", 32'(dut.mem_q[0].ctr), 0);
        drive(1, 32'h100, 0, 0, 32'h0, 0, 32'h100);
        idle(32'h100);
        chk("nt_sat_ctr", 32'(dut.mem_q[0].ctr), 0);
        drive(1, 32'h100, 1, 0, 32'h240, 0, 32'h100);
        idle(32'h100);
        chk("t_ctr", 32'(dut.mem_q[0].ctr), 1);
        chk("t_be", 32'(branch_en), 0);
        chk("t_tgt_refresh", pc_target, 32'h240);
        drive(1, 32'h140, 1, 0, 32'h500, 0, 32'h100);
        idle(32'h100);
        chk("alias_old_be", 32'(branch_en), 0);
        chk("alias_old_tgt", pc_target, 32'h500);
        idle(32'h140);
        chk("alias_new_be", 32'(branch_en), 1);
        chk("alias_new_ctr", 32'(dut.mem_q[0].ctr), 2);
        drive(1, 32'h20, 1, 1, 32'h80, 0, 32'h20);
        chk("jal_same_cycle_be", 32'(branch_en), 0);
        idle(32'h20);
        chk("jal_be", 32'(branch_en), 1);
        chk("jal_tgt", pc_target, 32'h80);
        chk("jal_ctr", 32'(dut.mem_q[8].ctr), 3);
        drive(1, 32'h20, 1, 0, 32'h80, 0, 32'h20);
        idle(32'h20);
        chk("st_sat_ctr", 32'(dut.mem_q[8].ctr), 3);
        drive(1, 32'h600, 0, 0, 32'h700, 0, 32'h140);
        idle(32'h140);
        chk("miss_nt_keep_be", 32'(branch_en), 1);
        chk("miss_nt_keep_tgt", pc_target, 32'h500);
        drive(1, 32'h300, 1, 0, 32'h900, 1, 32'h300);
        idle(32'h300);
        chk("clr_upd_be", 32'(branch_en), 0);
        chk("clr_upd_tgt", pc_target, 32'h500);
        idle(32'h20);
        chk("clr_jal_be", 32'(branch_en), 0);
        drive(1, 32'h20, 1, 1, 32'h80, 0, 32'h20);
        idle(32'h20);
        chk("realloc_be", 32'(branch_en), 1);
        @(posedge clk);
        #1;
        rst = 1; upd_en = 1; upd_pc = 32'h20; upd_taken = 1; upd_is_jump = 1; upd_target = 32'h44;
        @(posedge clk);
        #1;
        rst = 0; upd_en = 0;
        @(negedge clk);
        chk("midrst_be", 32'(branch_en), 0);
        chk("midrst_tgt", pc_target, 32'h0);
        chk("midrst_ctr", 32'(dut.mem_q[8].ctr), 1);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] upc;
            upc = 32'h1000 + 32'((i % 6) * 'h40) + 32'((i / 12) * 4) + ((i % 5 == 0) ? 32'h400 : 32'h0);
            drive(1, upc, (i % 3 != 0) || (i % 7 == 0), i % 7 == 0, 32'h8000 + 32'(i * 4),
                  i == 41, (i % 2 == 0) ? upc : 32'h1000 + 32'((i % 4) * 'h40));
        end
        idle(32'h1000);
        idle(32'h1040);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btb.md
# btb

Branch target buffer for the fetch-stage branch predictor. Each cycle it looks up the fetch PC and drives `branch_en` and `pc_target` to the next-PC unit: hit plus taken prediction selects the target, otherwise PC+4. The execute stage reports resolved branches and jumps back through an update port. The buffer allocates entries, trains 2-bit saturating counters and refreshes targets.

## Interface
- `WIDTH`, 32, PC and target width.
- `ENTRIES`, 16, number of direct-mapped entries; power of two, 2..256.
- `IDX_W`, `$clog2(ENTRIES)`, index width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_fetch`  in  WIDTH  PC being fetched this cycle.
- `branch_en`  out  1  predicted taken (valid hit and counter[1] set).
- `pc_target`  out  WIDTH  stored target of the indexed entry.
- `upd_en`  in  1  execute-stage resolution valid this cycle.
- `upd_pc`  in  WIDTH  PC of the resolved branch or jump.
- `upd_taken`  in  1  resolved direction; 1 for every jump.
- `upd_is_jump`  in  1  JAL/JALR, meaning unconditional.
- `upd_target`  in  WIDTH  resolved target address.
- `clr`  in  1  invalidate all entries, e.g. on fence.i.

## Operation
- PC split:
  - index = `pc[IDX_W+1:2]`.
  - tag = `pc[WIDTH-1:IDX_W+2]`.
  - `pc[1:0]` ignored.
- Entry fields: valid, tag, target, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup is combinational from `pc_fetch` and the registered array.
  - `branch_en` = valid & tag match & ctr[1].
  - `pc_target` = target of the indexed entry, regardless of hit.
- Update, when `upd_en`=1, index and tag taken from `upd_pc`:
  - Hit (valid and tag match):
    - jump: ctr forced to 11.
    - otherwise: saturating increment if `upd_taken`, saturating decrement if not.
    - target overwritten with `upd_target` only if `upd_taken`.
  - Miss and `upd_taken`=1: allocate, overwriting any conflicting entry. Valid=1, tag and target written, ctr = 11 if jump, else 10.
  - Miss and `upd_taken`=0: no change; not-taken branches are never allocated.
- `clr`=1 clears every valid bit at the next edge. Counters, tags and targets are retained but unused.
- `clr` and `upd_en` in the same cycle: `clr` wins and no allocation occurs.

## Timing
- Lookup has zero cycle latency: outputs are combinational in `pc_fetch` within the cycle.
- Updates commit at the rising edge after `upd_en` is sampled. A lookup in the same cycle to the same index sees the pre-update contents.
- Lookup and update ports are independent. One update per cycle; no backpressure and no handshake.
- Reset state:
  - all valid=0, ctr=01, target=0, tag=0.
  - hence `branch_en`=0 and `pc_target`=0 in the first cycle after reset, for any `pc_fetch`.
- Reset asserted mid-operation overrides `upd_en` and `clr` in that cycle.
- Counter boundaries: 11 + taken stays 11; 00 + not-taken stays 00.
- Saturated wrap-around is forbidden; a bench assertion checks it.

## Structure
- Shared package `bpu_pkg` holds:
  - the counter typedef `ctr2_t` and constants `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - the `btb_entry_t` struct, parameterised through `WIDTH`/`IDX_W` localparams.
- Sub-module `sat_ctr2`: combinational next-counter from current value, `taken`, `force_strong`. It is reused by any future direction predictor.
- Storage is an array of `btb_entry_t` flops, not inferred RAM, so reset and `clr` can clear every entry in one cycle.

## Test plan
- Reset, then lookup `pc_fetch`=0x100 -> `branch_en`=0, `pc_target`=0x0.
- Allocate and hit:
  - update `upd_pc`=0x100, taken, target 0x200, not jump.
  - next cycle lookup 0x100 -> `branch_en`=1, `pc_target`=0x200, ctr=10.
- Train down:
  - two not-taken updates at 0x100 -> ctr 10→01→00; lookup gives `branch_en`=0.
  - a third not-taken update leaves ctr at 00.
  - one taken update -> ctr=01, still `branch_en`=0.
- Alias conflict (ENTRIES=16):
  - allocate 0x100, then taken update at 0x140 (same index 0, different tag).
  - lookup 0x100 -> miss (`branch_en`=0); lookup 0x140 -> hit.
- Jump and bypass timing:
  - JAL update at 0x20 to 0x80 while `pc_fetch`=0x20 in the same cycle -> `branch_en`=0 that cycle.
  - next cycle `branch_en`=1, `pc_target`=0x80, ctr=11.
- `clr` with a simultaneous taken update at 0x300 -> next cycle every lookup, including 0x300, gives `branch_en`=0.
